// File: rtl/scan_config_loader_pkg.sv
// Shared definitions for the configuration scan-chain loader: FSM encoding,
// per-block chain lengths and a small helper used when sizing word transfers.
package scan_config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_WORD_W            = 8;
    localparam int CHAIN_LEN_SB_EDGE     = 12;  // 3 channels x 4 bits
    localparam int CHAIN_LEN_SB_INTERIOR = 24;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_config_loader_if.sv
// Host/chain-side bundle of the scan loader. The master side is the config host
// plus the chain tail; the slave side is the loader itself.
interface scan_config_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              scan_in;
    logic              scan_en;
    logic              scan_out;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_data, cfg_valid, scan_out,
        input  cfg_ready, scan_in, scan_en, rb_data, rb_valid, busy, done
    );

    modport slave (
        input  start, cfg_data, cfg_valid, scan_out,
        output cfg_ready, scan_in, scan_en, rb_data, rb_valid, busy, done
    );
endinterface

// File: rtl/scan_config_loader_rb_deser.sv
// Readback deserializer: collects the bits leaving the chain tail into words,
// LSB first, and pulses rb_valid once per full word or at the final chain bit.
module scan_rb_deser #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en_i,
    input  logic              scan_out_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] rb_data_o,
    output logic              rb_valid_o
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;
    logic              word_end;

    // A new word starts from zero so a short final word is zero-padded.
    always_comb begin
        sr_d        = (idx_q == '0) ? '0 : sr_q;
        sr_d[idx_q] = scan_out_i;
    end

    assign word_end = (idx_q == IDX_W'(WORD_W - 1)) || last_i;

    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            sr_q       <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (scan_en_i) begin
                sr_q <= sr_d;
                if (word_end) begin
                    rb_data_q  <= sr_d;
                    rb_valid_q <= 1'b1;
                    idx_q      <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign rb_data_o  = rb_data_q;
    assign rb_valid_o = rb_valid_q;
endmodule

// File: rtl/scan_config_loader.sv
// Scan-chain bitstream initiator: takes config words over valid/ready and
// shifts exactly CHAIN_LEN bits into the fabric chain, capturing readback.
module scan_config_loader
    import scan_config_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = CHAIN_LEN_SB_EDGE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scan_config_loader_if.slave   bus
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  total_q;
    logic [WB_W-1:0]   wbits_q;
    logic [WORD_W-1:0] shift_q;
    logic              cfg_ready_q;
    logic              scan_en_q;
    logic              busy_q;
    logic              done_q;

    logic [CNT_W-1:0]  remain;
    logic [WB_W-1:0]   load_bits;
    logic              last_bit;

    // The final word may be partial; its upper bits are never shifted.
    assign remain    = CNT_W'(CHAIN_LEN) - total_q;
    assign load_bits = WB_W'(min_u(WORD_W, 32'(remain)));
    assign last_bit  = (total_q == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            total_q     <= '0;
            wbits_q     <= '0;
            shift_q     <= '0;
            cfg_ready_q <= 1'b0;
            scan_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q     <= ST_LOAD;
                        total_q     <= '0;
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.cfg_valid && cfg_ready_q) begin
                        shift_q     <= bus.cfg_data;
                        wbits_q     <= load_bits;
                        cfg_ready_q <= 1'b0;
                        scan_en_q   <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_q <= shift_q >> 1;
                    total_q <= total_q + CNT_W'(1);
                    wbits_q <= wbits_q - WB_W'(1);
                    if (last_bit) begin
                        state_q   <= ST_DONE;
                        scan_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (wbits_q == WB_W'(1)) begin
                        state_q     <= ST_LOAD;
                        scan_en_q   <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    scan_rb_deser #(.WORD_W(WORD_W)) u_rb_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en_i  (scan_en_q),
        .scan_out_i (bus.scan_out),
        .last_i     (last_bit),
        .rb_data_o  (rb_data),
        .rb_valid_o (rb_valid)
    );

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.scan_in   = shift_q[0];
    assign bus.scan_en   = scan_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rb_data   = rb_data;
    assign bus.rb_valid  = rb_valid;
endmodule
